uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port uart_valid  input  1  UART receiver holds a received byte.
REQ-005 SHALL have port uart_data  input  8  received byte; stable while uart_valid is high.
REQ-006 SHALL have port uart_rd  output  1  one-cycle pulse that consumes the byte held by the UART receiver.
REQ-007 SHALL have port cpu_rd  input  1  one-cycle pop strobe from the I/O read decode.
REQ-008 SHALL have port rd_data  output  8  head-of-FIFO byte; first-word-fall-through.
REQ-009 SHALL have port rx_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag: a byte was dropped.
REQ-012 SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-013 SHALL register uart_rd; it asserts only when uart_valid=1, uart_rd was 0 in the previous cycle, and a push or discard is permitted (REQ-015, REQ-025, REQ-026).
- Two-cycle spacing is mandatory: the receiver deasserts valid one cycle after rd, so back-to-back pulses would double-consume.
REQ-014 SHALL write uart_data into the tail entry on the same edge that launches uart_rd (push); tail pointer wraps modulo DEPTH.
REQ-015 SHALL define full as count==DEPTH, evaluated before any same-cycle pop; no push is permitted when full.
REQ-016 SHALL present the head entry on rd_data combinationally from the storage array; rd_data is don't-care when rx_valid=0.
REQ-017 SHALL pop on cpu_rd=1 when rx_valid=1: head pointer advances modulo DEPTH and count decrements.
REQ-018 SHALL ignore cpu_rd while rx_valid=0, including on the cycle a push into an empty FIFO occurs; count then becomes 1.
REQ-019 SHALL leave count unchanged on a simultaneous push and pop with a non-empty FIFO.
REQ-020 SHALL make a pushed byte visible on rd_data/rx_valid on the cycle after the push edge (latency 1).
REQ-021 SHALL preserve byte order exactly, across pointer wrap-around.
REQ-022 SHALL, on ovf_clr=1 coinciding with a new overflow event, leave overflow set (set wins).

Reset
REQ-023 SHALL, while reset=1 at a clk edge, clear head, tail, count, overflow and uart_rd to 0, so rx_valid=0; storage contents are not reset.
REQ-024 SHALL, if reset arrives mid-operation, discard all buffered bytes; a byte still held by the receiver is taken normally once reset deasserts.

Configuration
REQ-025 SHALL, with macro UART_RX_FIFO_OVF_EN defined, pulse uart_rd when full to discard the incoming byte, write nothing, and set overflow.
REQ-026 SHALL, without UART_RX_FIFO_OVF_EN, never pulse uart_rd while full (back-pressure: byte stays in the receiver), tie overflow to 0 and ignore ovf_clr.

Verification
REQ-027 SHALL cover: reset, then uart_valid with 0x41 held until uart_rd -> exactly one uart_rd pulse; rx_valid=1, rd_data=0x41, count=1 one cycle later; cpu_rd -> rx_valid=0, count=0.
REQ-028 SHALL cover: push 0x00..0x0F with DEPTH=16, pop 8, push 0x10..0x17, pop all -> 0x00..0x17 returned in order; count=0 at end (wrap).
REQ-029 SHALL cover: FIFO holding 5 bytes, push and cpu_rd on the same cycle -> count stays 5, head advances by one.
REQ-030 SHALL cover: empty FIFO, cpu_rd on the push cycle of 0x55 -> count=1, rd_data=0x55 (pop ignored).
REQ-031 SHALL cover: 16 bytes queued, 17th byte 0xAA offered -> with UART_RX_FIFO_OVF_EN: uart_rd pulses, overflow=1, FIFO unchanged, ovf_clr clears flag; without: no uart_rd until one cpu_rd, then 0xAA enters as the 16th entry.
REQ-032 SHALL cover: reset asserted with 7 bytes queued -> next cycle count=0, rx_valid=0, overflow=0, uart_rd=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and the CPU read port, first-word-fall-through.
// Define UART_RX_FIFO_OVF_EN to drop bytes when full (sticky overflow); otherwise full back-pressures.
module uart_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_valid,
  input  logic [7:0]                 uart_data,
  output logic                       uart_rd,
  input  logic                       cpu_rd,
  output logic [7:0]                 rd_data,
  output logic                       rx_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          full;
  logic          take;
  logic          push;
  logic          pop;

  // Receiver handshake: the receiver holds uart_valid/uart_data until it sees a
  // one-cycle uart_rd, then drops valid on the following cycle. uart_rd is never
  // issued on two consecutive cycles, so a single byte cannot be consumed twice.
  assign full     = (cnt == CW'(DEPTH));
  assign rx_valid = (cnt != '0);
  assign pop      = cpu_rd && rx_valid;

`ifdef UART_RX_FIFO_OVF_EN
  // A full FIFO still accepts the byte from the receiver, but only to throw it away.
  assign take = uart_valid && !uart_rd;
`else
  assign take = uart_valid && !uart_rd && !full;
`endif

  // Full is judged before any same-cycle pop, so a pop never makes room for a push.
  assign push = take && !full;

  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      uart_rd <= 1'b0;
    end else begin
      uart_rd <= take;
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage has no reset; only the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[tail] <= uart_data;
  end

  assign rd_data = mem[head];
  assign count   = cnt;

`ifdef UART_RX_FIFO_OVF_EN
  logic ovf_q;

  // A new drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset)              ovf_q <= 1'b0;
    else if (take && full)  ovf_q <= 1'b1;
    else if (ovf_clr)       ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef UART_RX_FIFO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          uart_valid;
  logic [7:0]    uart_data;
  logic          uart_rd;
  logic          cpu_rd;
  logic [7:0]    rd_data;
  logic          rx_valid;
  logic [CW-1:0] count;
  logic          overflow;
  logic          ovf_clr;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic       m_rd    = 1'b0;
  logic       m_ovf   = 1'b0;
  bit         started = 1'b0;

  // Receiver model state
  logic [7:0] tx_q[$];
  bit         gap_en    = 1'b0;
  logic       rd_s      = 1'b0;
  int         rd_pulses = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_valid (uart_valid),
    .uart_data  (uart_data),
    .uart_rd    (uart_rd),
    .cpu_rd     (cpu_rd),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue updated from the spec's rules each rising edge.
  always @(posedge clk) begin
    logic m_full;
    logic m_take;
    if (reset) begin
      exp_q.delete();
      m_rd    = 1'b0;
      m_ovf   = 1'b0;
      started = 1'b1;
    end else if (started) begin
      m_full = (exp_q.size() == DEPTH);
      m_take = uart_valid && !m_rd && (!m_full || OVF_EN);
      if (cpu_rd && exp_q.size() != 0) void'(exp_q.pop_front());
      if (m_take && !m_full) exp_q.push_back(uart_data);
      if (OVF_EN) begin
        if (m_take && m_full) m_ovf = 1'b1;
        else if (ovf_clr)     m_ovf = 1'b0;
      end
      m_rd = m_take;
    end
  end

  // Compare process, sampling away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("rx_valid", rx_valid, exp_q.size() != 0);
      chk("count", count, exp_q.size());
      if (exp_q.size() != 0) chk("rd_data", rd_data, exp_q[0]);
      chk("uart_rd", uart_rd, m_rd);
      chk("overflow", overflow, m_ovf);
    end
    rd_s = uart_rd;
    if (uart_rd) rd_pulses++;
  end

  // Receiver driver: holds a byte until uart_rd, drops valid the cycle after.
  always @(posedge clk) begin
    #2;
    if (rd_s) uart_valid = 1'b0;
    if (!uart_valid && tx_q.size() != 0 && (!gap_en || $urandom_range(0, 2) == 0)) begin
      uart_data  = tx_q.pop_front();
      uart_valid = 1'b1;
    end
  end

  task automatic wait_count(input int n, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (count == CW'(n)) hit = 1'b1;
    end
    chk(name, count, n);
  endtask

  task automatic pop_chk(input logic [7:0] e, input string name);
    @(negedge clk);
    chk(name, rd_data, e);
    @(posedge clk); #1 cpu_rd = 1'b1;
    @(posedge clk); #1 cpu_rd = 1'b0;
  endtask

  initial begin
    int p0;
    bit hit;
    reset      = 1'b1;
    uart_valid = 1'b0;
    uart_data  = 8'h00;
    cpu_rd     = 1'b0;
    ovf_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_uart_rd", uart_rd, 0);
    chk("reset_overflow", overflow, 0);

    // Single byte 0x41
    @(posedge clk); #1;
    p0 = rd_pulses;
    tx_q.push_back(8'h41);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (uart_rd) hit = 1'b1;
    end
    chk("single_rd_seen", hit, 1);
    chk("single_rx_valid", rx_valid, 1);
    chk("single_rd_data", rd_data, 8'h41);
    chk("single_count", count, 1);
    repeat (5) @(posedge clk);
    chk("single_one_pulse", rd_pulses - p0, 1);
    #1 cpu_rd = 1'b1;
    @(posedge clk); #1 cpu_rd = 1'b0;
    @(negedge clk);
    chk("single_pop_rx_valid", rx_valid, 0);
    chk("single_pop_count", count, 0);

    // Wrap-around ordering
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
    wait_count(16, "wrap_fill16");
    for (int i = 0; i < 8; i++) pop_chk(8'(i), "wrap_pop_a");
    for (int i = 16; i < 24; i++) tx_q.push_back(8'(i));
    wait_count(16, "wrap_refill16");
    for (int i = 8; i < 24; i++) pop_chk(8'(i), "wrap_pop_b");
    @(negedge clk);
    chk("wrap_end_count", count, 0);

    // Simultaneous push and pop with 5 queued
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) tx_q.push_back(8'(8'h60 + i));
    wait_count(5, "pp_fill5");
    @(posedge clk); #1;
    tx_q.push_back(8'h65);
    cpu_rd = 1'b1;
    @(posedge clk); #1 cpu_rd = 1'b0;
    @(negedge clk);
    chk("pp_count", count, 5);
    chk("pp_head", rd_data, 8'h61);
    for (int i = 1; i < 6; i++) pop_chk(8'(8'h60 + i), "pp_drain");

    // Pop ignored on the push cycle into an empty FIFO
    @(posedge clk); #1;
    tx_q.push_back(8'h55);
    cpu_rd = 1'b1;
    @(posedge clk); #1 cpu_rd = 1'b0;
    @(negedge clk);
    chk("empty_pp_count", count, 1);
    chk("empty_pp_data", rd_data, 8'h55);
    pop_chk(8'h55, "empty_pp_drain");

    // Full FIFO offered 0xAA
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) tx_q.push_back(8'(8'h80 + i));
    wait_count(16, "full_fill16");
    @(posedge clk); #1;
    p0 = rd_pulses;
    tx_q.push_back(8'hAA);
    repeat (6) @(posedge clk);
    if (OVF_EN) begin
      chk("full_ovf_pulses", rd_pulses - p0, 1);
      @(negedge clk);
      chk("full_ovf_flag", overflow, 1);
      chk("full_ovf_count", count, 16);
      chk("full_ovf_head", rd_data, 8'h80);
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk);
      chk("full_ovf_clr", overflow, 0);
      for (int i = 0; i < 16; i++) pop_chk(8'(8'h80 + i), "full_ovf_drain");
    end else begin
      chk("full_bp_pulses", rd_pulses - p0, 0);
      @(negedge clk);
      chk("full_bp_flag", overflow, 0);
      chk("full_bp_count", count, 16);
      pop_chk(8'h80, "full_bp_pop");
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("full_bp_refill", count, 16);
      for (int i = 1; i < 16; i++) pop_chk(8'(8'h80 + i), "full_bp_drain");
      pop_chk(8'hAA, "full_bp_last");
    end
    @(negedge clk);
    chk("full_end_count", count, 0);

    // Reset with 7 queued
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) tx_q.push_back(8'(8'hC0 + i));
    wait_count(7, "rst_fill7");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_uart_rd", uart_rd, 0);

    // Randomized traffic: alternate drain-heavy and fill-heavy phases
    gap_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if ((c / 250) % 2 == 1) cpu_rd = ($urandom_range(0, 9) == 0);
      else                    cpu_rd = ($urandom_range(0, 1) == 1);
      if (tx_q.size() < 3) tx_q.push_back(8'($urandom_range(0, 255)));
      ovf_clr = ($urandom_range(0, 15) == 0);
      reset   = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk); #1;
    cpu_rd  = 1'b0;
    ovf_clr = 1'b0;
    reset   = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
